// File: rtl/div_unit.sv
// Sequential 32-bit signed divider (MIPS DIV semantics): quotient to LO, remainder to HI.
// One restoring-division step per clock under a start/done handshake with the control unit.
module div_unit (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [31:0] dividend,
    input  logic signed [31:0] divisor,
    output logic        [31:0] lo_out,
    output logic        [31:0] hi_out,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_q_q, sign_q_d;
    logic        sign_r_q, sign_r_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        divz_q, divz_d;

    logic [32:0] shifted;
    logic [32:0] trial;

    // Two's-complement negate when neg is set; wraps 0x80000000 onto itself.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        divz_d   = 1'b0;
        shifted  = {rem_q, quo_q[31]};
        trial    = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        divz_d = 1'b1;
                    end else begin
                        quo_d    = cond_neg(dividend, dividend[31]);
                        dvs_d    = cond_neg(divisor, divisor[31]);
                        rem_d    = '0;
                        cnt_d    = '0;
                        sign_q_d = dividend[31] ^ divisor[31];
                        sign_r_d = dividend[31];
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // A set borrow bit means the trial went negative: restore.
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                lo_d    = cond_neg(quo_q, sign_q_q);
                hi_d    = cond_neg(rem_q, sign_r_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end

    assign lo_out   = lo_q;
    assign hi_out   = hi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: hand-computed quotient/remainder vectors and handshake timing.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int vectors;
    int miscompares;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .lo_out   (lo_out),
        .hi_out   (hi_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start pulse and waits (bounded) for done; returns edges from E0 to done
    // and the number of cycles busy was observed high.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int bcnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        bcnt = 0;
        @(negedge clk);
        if (busy === 1'b1) bcnt++;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({lo_out, hi_out} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_results: got lo=%h hi=%h, want 0/0", lo_out, hi_out);
        end
        vectors++;
        if ({busy, done, div_zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got busy/done/dz=%b, want 000", {busy, done, div_zero});
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        do_div(32'd7, 32'd2, cyc, bcnt);
        vectors++;
        if (cyc !== 33) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, want 33", cyc);
        end
        vectors++;
        if (bcnt !== 33) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d, want 33", bcnt);
        end
        vectors++;
        if (lo_out !== 32'd3 || hi_out !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_7_2: got lo=%h hi=%h, want 3/1", lo_out, hi_out);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_drop: got %b, want 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got %b, want 0", done);
        end
    endtask

    task automatic test_values();
        logic [31:0] tv [7][4];
        int cyc, bcnt;
        tv = '{
            '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF},
            '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1},
            '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF},
            '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0},
            '{32'd0,        32'd5,        32'd0,        32'd0},
            '{32'd5,        32'd7,        32'd0,        32'd5},
            '{32'd1000000,  32'd37,       32'd27027,    32'd1}
        };
        for (int i = 0; i < 7; i++) begin
            do_div(tv[i][0], tv[i][1], cyc, bcnt);
            vectors++;
            if (cyc !== 33 || lo_out !== tv[i][2] || hi_out !== tv[i][3]) begin
                miscompares++;
                $display("FAIL value_%0d (%h/%h): got lo=%h hi=%h lat=%0d, want lo=%h hi=%h lat=33",
                         i, tv[i][0], tv[i][1], lo_out, hi_out, cyc, tv[i][2], tv[i][3]);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc, bcnt;
        do_div(32'd7, 32'd2, cyc, bcnt);
        @(negedge clk);
        dividend = 32'd99;
        divisor  = 32'd0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({div_zero, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL dz_flags: got dz/busy/done=%b, want 100", {div_zero, busy, done});
        end
        vectors++;
        if (lo_out !== 32'd3 || hi_out !== 32'd1) begin
            miscompares++;
            $display("FAIL dz_retain: got lo=%h hi=%h, want 3/1", lo_out, hi_out);
        end
        @(negedge clk);
        vectors++;
        if ({div_zero, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL dz_one_cycle: got dz/busy/done=%b, want 000", {div_zero, busy, done});
        end
    endtask

    task automatic test_disturb();
        int cyc;
        logic dz_seen;
        dz_seen = 1'b0;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = 32'hDEADBEEF;
        divisor  = 32'h00000003;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 3 || cyc == 20) start = 1'b1;
            if (cyc == 4 || cyc == 21) start = 1'b0;
            if (cyc == 10) begin
                divisor = 32'd0;
                start   = 1'b1;
            end
            if (cyc == 11) start = 1'b0;
            if (cyc == 15) dividend = 32'd5;
            @(negedge clk);
            if (div_zero === 1'b1) dz_seen = 1'b1;
        end
        vectors++;
        if (cyc !== 33 || lo_out !== 32'd14 || hi_out !== 32'd2) begin
            miscompares++;
            $display("FAIL disturb_100_7: got lo=%h hi=%h lat=%0d, want 14/2 lat=33", lo_out, hi_out, cyc);
        end
        vectors++;
        if (dz_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL disturb_no_dz: got %b, want 0", dz_seen);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bcnt;
        logic done_seen;
        done_seen = 1'b0;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || lo_out !== 32'd0 || hi_out !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_state: got busy=%b done=%b lo=%h hi=%h, want 0/0/0/0",
                     busy, done, lo_out, hi_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        vectors++;
        if (done_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got activity=%b, want 0", done_seen);
        end
        do_div(32'd9, 32'd3, cyc, bcnt);
        vectors++;
        if (cyc !== 33 || lo_out !== 32'd3 || hi_out !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_restart: got lo=%h hi=%h lat=%0d, want 3/0 lat=33", lo_out, hi_out, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, cyc2;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (cyc !== 33 || lo_out !== 32'd14 || hi_out !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_first: got lo=%h hi=%h lat=%0d, want 14/2 lat=33", lo_out, hi_out, cyc);
        end
        dividend = 32'd9;
        divisor  = 32'd3;
        cyc2 = 0;
        while (cyc2 < 100) begin
            @(posedge clk);
            cyc2++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        start = 1'b0;
        vectors++;
        if (cyc2 !== 34) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d, want 34", cyc2);
        end
        vectors++;
        if (lo_out !== 32'd3 || hi_out !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_second: got lo=%h hi=%h, want 3/0", lo_out, hi_out);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_disturb();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential 32-bit signed integer divider for the multicycle CPU datapath, downstream of the A/B operand registers. It produces the quotient into LO and the remainder into HI, which feed the register-file write-data mux. It runs one restoring-division step per clock under a start/done handshake with the control unit. It flags division by zero so the control unit can enter its exception sequence.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a division; sampled only in IDLE
- dividend  in  32  signed dividend, driven by register A output
- divisor  in  32  signed divisor, driven by register B output
- lo_out  out  32  quotient of the last completed division
- hi_out  out  32  remainder of the last completed division
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse when lo_out/hi_out hold a new result
- div_zero  out  1  one-cycle pulse when start is accepted with divisor == 0

## Operation
- States:
  - IDLE: waits for start.
  - RUN: performs the 32 iteration steps.
  - FINISH: applies signs and writes the results.
- IDLE, start=1, divisor != 0:
  - Capture the unsigned magnitudes |dividend| and |divisor|.
  - Capture sign_q = dividend[31] XOR divisor[31] and sign_r = dividend[31].
  - Clear the 33-bit partial remainder and the 6-bit step counter.
  - busy <= 1, go to RUN.
- IDLE, start=1, divisor == 0:
  - div_zero <= 1 for one cycle.
  - Stay in IDLE with busy=0.
  - lo_out/hi_out unchanged; done is not asserted.
- RUN step:
  - Shift {remainder, quotient} left by one, bringing in the next dividend magnitude bit (MSB first).
  - Trial-subtract the divisor magnitude (33-bit).
  - If the result is non-negative, keep it and set quotient bit 0 to 1; otherwise restore and set the bit to 0.
  - Counter increments; after step 32 go to FINISH.
- FINISH:
  - lo_out <= sign_q ? -quotient : quotient.
  - hi_out <= sign_r ? -remainder[31:0] : remainder[31:0].
  - done <= 1 for one cycle, busy <= 0, go to IDLE.
- Semantics follow MIPS DIV:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo_out = 0x80000000, hi_out = 0. This falls out of unsigned 32-bit magnitudes with wrap on negation; no special case and no flag.
- lo_out/hi_out are written only in FINISH and hold their values otherwise.
- start while busy=1 is ignored; the running operation is not disturbed.
- dividend/divisor are sampled only at the accepting edge; later changes on A/B have no effect.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, busy=0, done=0, div_zero=0;
  - lo_out=0, hi_out=0;
  - all internal registers cleared.
- Reset mid-operation aborts the division with no done pulse. The first start after reset release is accepted normally.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy is high from after E0 through the cycle following E32.
  - Iteration steps occur on E1..E32.
  - FINISH executes on E33: results become visible and done is high for the cycle after E33. busy drops after E33.
- Latency from E0 to done is 33 cycles. Throughput is one division per 34 cycles when start is held or re-asserted during the done cycle.
- The done cycle is IDLE, so start=1 in that cycle is accepted on the next edge (back-to-back).
- div_zero is high for exactly the cycle after E0; busy stays 0 throughout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- 7 / 2: done 33 cycles after the start edge, lo_out=0x00000003, hi_out=0x00000001, busy high for 33 cycles.
- Signs:
  - -7 / 2 gives lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
  - 7 / -2 gives lo_out=0xFFFFFFFD, hi_out=0x00000001.
  - -7 / -2 gives lo_out=0x00000003, hi_out=0xFFFFFFFF.
- Edge values:
  - 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0.
  - 0 / 5 gives lo_out=0, hi_out=0.
  - 5 / 7 gives lo_out=0, hi_out=5.
- Divide by zero after a prior 7/2 result:
  - div_zero is high for one cycle; busy and done stay 0.
  - lo_out=3 and hi_out=1 are retained.
- Mid-operation disturbances:
  - start pulses and A/B changes during RUN do not alter the 100/7 result (lo_out=14, hi_out=2).
  - reset=0 asserted at step 10 gives busy=0, lo_out=hi_out=0, and no done pulse.
- Back-to-back: start held high across two divisions (100/7, then 9/3).
  - Second done arrives 34 cycles after the first.
  - Results are lo_out=3, hi_out=0.
